// File: rtl/usb_fs_in_ep_buf.sv
// Single-packet IN endpoint buffer: collects bytes from the endpoint, commits them as one packet,
// replays it to the USB protocol engine until ACKed, and tracks the DATA0/DATA1 toggle and STALL.
module usb_fs_in_ep_buf #(
    parameter int MAX_PKT_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       in_token,
    input  logic       setup_rcvd,
    output logic       ep_ready,
    output logic       ep_stalled,
    output logic       data_toggle,
    output logic       tx_data_avail,
    output logic [7:0] tx_data,
    input  logic       tx_data_get,
    input  logic       tx_acked,
    input  logic       tx_retry,
    output logic [1:0] dbg_state
);

    localparam int AW = (MAX_PKT_SIZE > 1) ? $clog2(MAX_PKT_SIZE) : 1;
    localparam logic [6:0] MAX_LEN = 7'(MAX_PKT_SIZE);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        READY    = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] mem [MAX_PKT_SIZE];
    logic [6:0] wr_cnt;
    logic [6:0] wr_cnt_inc;
    logic [6:0] pkt_len;
    logic [6:0] rd_ptr;
    logic       toggle;
    logic       stall;
    logic       acked_q;

    logic       wr_en;
    logic       commit;
    logic [6:0] commit_len;
    logic       start_send;
    logic       rewind;
    logic       ack_now;

    assign wr_cnt_inc      = wr_cnt + 7'd1;
    assign in_ep_grant     = in_ep_req && (state == FILL);
    assign in_ep_data_free = (state == FILL) && (wr_cnt < MAX_LEN);
    assign wr_en           = in_ep_data_put && in_ep_grant && in_ep_data_free;

    // The read is gated so tx_data idles at zero outside an active byte.
    assign tx_data_avail = (state == SEND) && (rd_ptr < pkt_len);
    assign tx_data       = tx_data_avail ? mem[rd_ptr[AW-1:0]] : 8'h00;

    assign ep_ready    = (state != FILL) && !stall;
    assign ep_stalled  = stall;
    assign data_toggle = toggle;
    assign in_ep_acked = acked_q;
    assign dbg_state   = state;

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        commit_len = wr_cnt;
        start_send = 1'b0;
        rewind     = 1'b0;
        ack_now    = 1'b0;
        if (setup_rcvd) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL: begin
                    // A done coinciding with the final byte still yields a single commit.
                    if (wr_en && (wr_cnt_inc == MAX_LEN)) begin
                        commit     = 1'b1;
                        commit_len = wr_cnt_inc;
                    end else if (in_ep_data_done) begin
                        commit     = 1'b1;
                        commit_len = wr_en ? wr_cnt_inc : wr_cnt;
                    end
                    if (commit) state_next = READY;
                end
                READY: begin
                    if (in_token && !stall && !in_ep_stall) begin
                        start_send = 1'b1;
                        state_next = SEND;
                    end
                end
                SEND: begin
                    if (tx_retry) begin
                        rewind     = 1'b1;
                        state_next = READY;
                    end else if (!tx_data_avail) begin
                        state_next = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_acked) begin
                        ack_now    = 1'b1;
                        state_next = FILL;
                    end else if (tx_retry) begin
                        rewind     = 1'b1;
                        state_next = READY;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            wr_cnt  <= 7'd0;
            pkt_len <= 7'd0;
            rd_ptr  <= 7'd0;
            toggle  <= 1'b0;
            stall   <= 1'b0;
            acked_q <= 1'b0;
        end else begin
            state   <= state_next;
            acked_q <= ack_now;
            if (setup_rcvd) begin
                wr_cnt  <= 7'd0;
                pkt_len <= 7'd0;
                rd_ptr  <= 7'd0;
                toggle  <= 1'b1;
                stall   <= 1'b0;
            end else begin
                if (ack_now) wr_cnt <= 7'd0;
                else if (wr_en) wr_cnt <= wr_cnt_inc;
                if (commit) pkt_len <= commit_len;
                if (start_send || rewind) rd_ptr <= 7'd0;
                else if (tx_data_get && tx_data_avail) rd_ptr <= rd_ptr + 7'd1;
                if (ack_now) toggle <= ~toggle;
                // A handshake in the same cycle outranks a stall request.
                if (in_ep_stall && !ack_now && !rewind) stall <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[AW-1:0]] <= in_ep_data;
    end

endmodule

// File: tb/tb_usb_fs_in_ep_buf.sv
// Bench for usb_fs_in_ep_buf: random packets checked against a byte-queue model of the
// endpoint transfer, plus directed stall, ZLP, retry and reset scenarios.
module tb_usb_fs_in_ep_buf;

    localparam int MAX = 32;
    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       in_token;
    logic       setup_rcvd;
    logic       ep_ready;
    logic       ep_stalled;
    logic       data_toggle;
    logic       tx_data_avail;
    logic [7:0] tx_data;
    logic       tx_data_get;
    logic       tx_acked;
    logic       tx_retry;
    logic [1:0] dbg_state;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    logic       exp_toggle;

    always #5 clk = ~clk;

    usb_fs_in_ep_buf #(.MAX_PKT_SIZE(MAX)) dut (
        .clk(clk),
        .reset(reset),
        .in_ep_req(in_ep_req),
        .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall),
        .in_ep_acked(in_ep_acked),
        .in_token(in_token),
        .setup_rcvd(setup_rcvd),
        .ep_ready(ep_ready),
        .ep_stalled(ep_stalled),
        .data_toggle(data_toggle),
        .tx_data_avail(tx_data_avail),
        .tx_data(tx_data),
        .tx_data_get(tx_data_get),
        .tx_acked(tx_acked),
        .tx_retry(tx_retry),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, dbg_state, ST_FILL);
        check({tag, "_ep_ready"}, ep_ready, 1'b0);
        check({tag, "_ep_stalled"}, ep_stalled, 1'b0);
        check({tag, "_avail"}, tx_data_avail, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_acked"}, in_ep_acked, 1'b0);
        check({tag, "_free"}, in_ep_data_free, 1'b1);
        check({tag, "_toggle"}, data_toggle, 1'b0);
        in_ep_req = 1'b1;
        settle();
        check({tag, "_grant_req1"}, in_ep_grant, 1'b1);
        in_ep_req = 1'b0;
        settle();
        check({tag, "_grant_req0"}, in_ep_grant, 1'b0);
    endtask

    // mode 0: auto-commit only, 1: done with the last put, 2: done in its own cycle
    task automatic write_packet(input int len, input int mode);
        logic [7:0] b;
        bit         early;
        exp_q.delete();
        in_ep_req = 1'b1;
        settle();
        check("grant_in_fill", in_ep_grant, 1'b1);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            in_ep_data      = b;
            in_ep_data_put  = 1'b1;
            in_ep_data_done = (mode == 1) && (i == len - 1);
            settle();
            check("free_during_fill", in_ep_data_free, 1'b1);
            tick();
        end
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        early = (len == MAX) || (mode == 1 && len > 0);
        check("ready_after_puts", ep_ready, early);
        if (!early) begin
            in_ep_data_done = 1'b1;
            tick();
            in_ep_data_done = 1'b0;
        end
        check("commit_ready", ep_ready, 1'b1);
        check("commit_state", dbg_state, ST_READY);
        check("free_outside_fill", in_ep_data_free, 1'b0);
        check("grant_outside_fill", in_ep_grant, 1'b0);
        // Stray put and done while READY must be dropped.
        in_ep_data      = 8'($urandom_range(0, 255));
        in_ep_data_put  = 1'b1;
        in_ep_data_done = 1'b1;
        tick();
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        in_ep_req       = 1'b0;
        check("stray_keeps_ready", dbg_state, ST_READY);
    endtask

    task automatic read_packet(input int retry_at);
        int len;
        int i;
        bit retried;
        len     = exp_q.size();
        i       = 0;
        retried = 1'b0;
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        check("avail_after_token", tx_data_avail, len > 0);
        check("state_send", dbg_state, ST_SEND);
        check("pid_toggle", data_toggle, exp_toggle);
        while (i < len) begin
            if (!retried && i == retry_at) begin
                tx_retry = 1'b1;
                tick();
                tx_retry = 1'b0;
                retried  = 1'b1;
                check("retry_state", dbg_state, ST_READY);
                check("retry_toggle", data_toggle, exp_toggle);
                in_token = 1'b1;
                tick();
                in_token = 1'b0;
                i = 0;
            end
            repeat ($urandom_range(0, 1)) begin
                tick();
                check("idle_avail", tx_data_avail, 1'b1);
            end
            check("byte_avail", tx_data_avail, 1'b1);
            check("byte_data", tx_data, exp_q[i]);
            tx_data_get = 1'b1;
            tick();
            tx_data_get = 1'b0;
            i++;
        end
        check("avail_drained", tx_data_avail, 1'b0);
        check("data_idle", tx_data, 8'h00);
        tx_data_get = 1'($urandom_range(0, 1));
        tick();
        tx_data_get = 1'b0;
        check("state_wait_ack", dbg_state, ST_WAIT);
        check("avail_in_wait", tx_data_avail, 1'b0);
    endtask

    task automatic ack_packet();
        tx_acked = 1'b1;
        settle();
        check("acked_not_early", in_ep_acked, 1'b0);
        tick();
        tx_acked = 1'b0;
        check("acked_pulse", in_ep_acked, 1'b1);
        check("free_after_ack", in_ep_data_free, 1'b1);
        check("state_after_ack", dbg_state, ST_FILL);
        check("toggle_flipped", data_toggle, !exp_toggle);
        exp_toggle = !exp_toggle;
        tick();
        check("acked_one_cycle", in_ep_acked, 1'b0);
    endtask

    task automatic do_packet(input int len, input int mode, input int retry_at);
        write_packet(len, mode);
        read_packet(retry_at);
        ack_packet();
    endtask

    task automatic do_setup();
        setup_rcvd = 1'b1;
        tick();
        setup_rcvd = 1'b0;
        exp_toggle = 1'b1;
        check("setup_state", dbg_state, ST_FILL);
        check("setup_toggle", data_toggle, 1'b1);
        check("setup_stall_clear", ep_stalled, 1'b0);
        check("setup_free", in_ep_data_free, 1'b1);
        check("setup_not_ready", ep_ready, 1'b0);
    endtask

    initial begin
        int len;
        int mode;
        int retry_at;
        reset = 1'b0;
        in_ep_req = 1'b0;
        in_ep_data_put = 1'b0;
        in_ep_data = 8'h00;
        in_ep_data_done = 1'b0;
        in_ep_stall = 1'b0;
        in_token = 1'b0;
        setup_rcvd = 1'b0;
        tx_data_get = 1'b0;
        tx_acked = 1'b0;
        tx_retry = 1'b0;
        exp_toggle = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        do_packet(18, 2, -1);

        do_setup();
        do_packet(32, 0, -1);
        do_packet(32, 0, -1);
        do_packet(3, 1, -1);

        do_packet(0, 2, -1);
        do_packet(8, 1, 5);

        write_packet(6, 2);
        in_ep_stall = 1'b1;
        tick();
        in_ep_stall = 1'b0;
        check("stall_latched", ep_stalled, 1'b1);
        check("stall_not_ready", ep_ready, 1'b0);
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        check("stall_token_ignored", dbg_state, ST_READY);
        check("stall_no_avail", tx_data_avail, 1'b0);
        do_setup();

        do_packet(32, 1, -1);

        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(0, MAX);
            mode = (len == MAX) ? $urandom_range(0, 2) : $urandom_range(1, 2);
            retry_at = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : -1;
            do_packet(len, mode, retry_at);
        end

        write_packet(4, 2);
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        tx_data_get = 1'b1;
        tick();
        tx_data_get = 1'b0;
        check("send_before_reset", dbg_state, ST_SEND);
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        reset = 1'b1;
        exp_toggle = 1'b0;
        tick();
        check("post_reset_no_ack", in_ep_acked, 1'b0);
        check("post_reset_state", dbg_state, ST_FILL);
        do_packet(5, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
